// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file: byte lane width,
// byte-enable width helper and the per-lane write merge.
package regfile_pkg;

  localparam int BYTE_W = 8;

  function automatic int be_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // One byte lane of a byte-enabled write: keep the old lane unless enabled.
  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] old_val,
    input logic [BYTE_W-1:0] nxt_val,
    input logic              be
  );
    return be ? nxt_val : old_val;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: 1-cycle latency, a valid flag per read,
// same-edge write forwarding when BYPASS is set.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_en,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]   entries,
  input  logic                           wr_ok,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_merged,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid
);

  logic [DATA_W-1:0] rd_next;
  logic              addr_ok;

  assign addr_ok = (32'(rd_addr) < DEPTH) && !((ZERO_REG != 0) && (rd_addr == '0));

  always_comb begin
    rd_next = '0;
    if (addr_ok) begin
      rd_next = entries[rd_addr];
      // wr_ok already excludes dropped writes, so only real writes forward.
      if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr)) begin
        rd_next = wr_merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w_sync.sv
// Register file, two registered read ports and one byte-enabled write port,
// synchronous clear; optional hardwired-zero entry 0 and write-to-read bypass.
module regfile_2r1w_sync
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int BE_W    = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_valid1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid2
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         wr_in_range;
  logic                         wr_ok;
  logic [DATA_W-1:0]            wr_old;
  logic [DATA_W-1:0]            wr_merged;

  assign wr_in_range = (32'(wr_addr) < DEPTH);
  assign wr_ok = wr_en && (wr_be != '0) && wr_in_range &&
                 !((ZERO_REG != 0) && (wr_addr == '0));
  assign wr_old = wr_in_range ? mem[wr_addr] : '0;

  always_comb begin
    wr_merged = '0;
    for (int k = 0; k < BE_W; k++) begin
      wr_merged[k*BYTE_W +: BYTE_W] =
        byte_merge(wr_old[k*BYTE_W +: BYTE_W], wr_data[k*BYTE_W +: BYTE_W], wr_be[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Reset is applied inside each port, so a read presented with rst is dropped.
  regfile_read_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .rd_addr(rd_addr1), .entries(mem),
    .wr_ok(wr_ok), .wr_addr(wr_addr), .wr_merged(wr_merged),
    .rd_data(rd_data1), .rd_valid(rd_valid1)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd2 (
    .clk(clk), .rst(rst), .rd_en(rd_en2), .rd_addr(rd_addr2), .entries(mem),
    .wr_ok(wr_ok), .wr_addr(wr_addr), .wr_merged(wr_merged),
    .rd_data(rd_data2), .rd_valid(rd_valid2)
  );

endmodule

// File: tb/tb_regfile_2r1w_sync.sv
// Three register-file configurations driven by shared stimulus and checked
// every cycle against an array model, plus hand-computed expectations.
module tb_regfile_2r1w_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en1 = 1'b0, rd_en2 = 1'b0;
  logic [2:0]  rd_addr1 = '0, rd_addr2 = '0;

  logic [7:0]  d0_rd1, d0_rd2;
  logic [31:0] d1_rd1, d1_rd2, d2_rd1, d2_rd2;
  logic        d0_v1, d0_v2, d1_v1, d1_v2, d2_v1, d2_v2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // d0: defaults; d1: 32-bit, bypass; d2: 32-bit, DEPTH=6, no bypass, zero entry
  regfile_2r1w_sync u_d0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0:0]), .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(d0_rd1),
    .rd_valid1(d0_v1), .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(d0_rd2),
    .rd_valid2(d0_v2)
  );

  regfile_2r1w_sync #(.DATA_W(32), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u_d1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(d1_rd1),
    .rd_valid1(d1_v1), .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(d1_rd2),
    .rd_valid2(d1_v2)
  );

  regfile_2r1w_sync #(.DATA_W(32), .DEPTH(6), .BYPASS(0), .ZERO_REG(1)) u_d2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(d2_rd1),
    .rd_valid1(d2_v1), .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(d2_rd2),
    .rd_valid2(d2_v2)
  );

  int depth_c [3] = '{8, 8, 6};
  bit byp_c   [3] = '{1'b1, 1'b1, 1'b0};
  bit zr_c    [3] = '{1'b0, 1'b0, 1'b1};
  int nb_c    [3] = '{1, 4, 4};

  logic [31:0] mem_m  [3][8];
  logic [31:0] pend_d [3][2];
  logic        pend_v [3][2];
  logic [31:0] cur_d  [3][2];
  logic        cur_v  [3][2];
  logic [31:0] dut_d  [3][2];
  logic        dut_v  [3][2];

  assign dut_d[0][0] = {24'h0, d0_rd1};
  assign dut_d[0][1] = {24'h0, d0_rd2};
  assign dut_d[1][0] = d1_rd1;
  assign dut_d[1][1] = d1_rd2;
  assign dut_d[2][0] = d2_rd1;
  assign dut_d[2][1] = d2_rd2;
  assign dut_v[0][0] = d0_v1;
  assign dut_v[0][1] = d0_v2;
  assign dut_v[1][0] = d1_v1;
  assign dut_v[1][1] = d1_v2;
  assign dut_v[2][0] = d2_v1;
  assign dut_v[2][1] = d2_v2;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] v;
    v = old;
    for (int k = 0; k < 4; k++) if (b[k]) v[8*k +: 8] = d[8*k +: 8];
    return v;
  endfunction

  // Apply one cycle of inputs, predict outputs after the coming edge, advance.
  task automatic drive(input bit r, input bit we, input logic [2:0] wa,
                       input logic [31:0] wd, input logic [3:0] wbe,
                       input bit e1, input logic [2:0] a1,
                       input bit e2, input logic [2:0] a2);
    logic [31:0] d, v;
    logic [3:0]  b;
    logic [2:0]  ad;
    bit          wv, en;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_en1 = e1; rd_addr1 = a1; rd_en2 = e2; rd_addr2 = a2;
    for (int i = 0; i < 3; i++) begin
      d  = (nb_c[i] == 1) ? {24'h0, wd[7:0]} : wd;
      b  = (nb_c[i] == 1) ? {3'b0, wbe[0]} : wbe;
      wv = !r && we && (b != 4'h0) && (int'(wa) < depth_c[i]) && !(zr_c[i] && wa == 3'd0);
      for (int p = 0; p < 2; p++) begin
        ad = (p == 0) ? a1 : a2;
        en = (p == 0) ? e1 : e2;
        if (r) begin
          pend_v[i][p] = 1'b0;
          pend_d[i][p] = '0;
        end else if (en) begin
          v = '0;
          if (int'(ad) < depth_c[i] && !(zr_c[i] && ad == 3'd0)) begin
            v = mem_m[i][ad];
            if (byp_c[i] && wv && wa == ad) v = merge(v, d, b);
          end
          pend_v[i][p] = 1'b1;
          pend_d[i][p] = v;
        end else begin
          pend_v[i][p] = 1'b0;
        end
      end
      if (r) begin
        for (int j = 0; j < 8; j++) mem_m[i][j] = '0;
      end else if (wv) begin
        mem_m[i][wa] = merge(mem_m[i][wa], d, b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 2; p++) begin
        cur_d[i][p] = pend_d[i][p];
        cur_v[i][p] = pend_v[i][p];
      end
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (dut_d[i][p] !== cur_d[i][p] || dut_v[i][p] !== cur_v[i][p]) begin
          errors++;
          $display("FAIL model inst%0d port%0d t=%0t: got d=%h v=%b want d=%h v=%b",
                   i, p + 1, $time, dut_d[i][p], dut_v[i][p], cur_d[i][p], cur_v[i][p]);
        end
      end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 8; j++) mem_m[i][j] = '0;
      for (int p = 0; p < 2; p++) begin
        pend_d[i][p] = '0;
        pend_v[i][p] = 1'b0;
      end
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset clear after preloading 0xAA everywhere
    for (int a = 0; a < 8; a++) drive(0, 1, 3'(a), 32'hAAAAAAAA, 4'hF, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
    chk("rst_valid1", {31'b0, d0_v1}, 32'h0);
    chk("rst_data2", d1_rd2, 32'h0);
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 0, 0, 1, 3'(a), 1, 3'(a));
      chk("clr_data1", {24'h0, d0_rd1}, 32'h0);
      chk("clr_valid2", {31'b0, d1_v2}, 32'h1);
    end

    // byte-enabled write
    drive(0, 1, 3, 32'h11223344, 4'hF, 0, 0, 0, 0);
    drive(0, 1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 3, 0, 0);
    chk("be_merge32", d1_rd1, 32'h11BB33DD);
    chk("be_merge32_d2", d2_rd1, 32'h11BB33DD);
    chk("be_merge8", {24'h0, d0_rd1}, 32'hDD);

    // bypass on/off
    drive(0, 1, 5, 32'h10, 4'h1, 0, 0, 0, 0);
    drive(0, 1, 5, 32'h7E, 4'h1, 1, 5, 0, 0);
    chk("bypass_on8", {24'h0, d0_rd1}, 32'h7E);
    chk("bypass_on32", d1_rd1, 32'h7E);
    chk("bypass_off", d2_rd1, 32'h10);
    drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
    chk("bypass_off_next", d2_rd1, 32'h7E);

    // zero entry and out-of-range write/read
    drive(0, 1, 0, 32'hFF, 4'hF, 0, 0, 0, 0);
    drive(0, 1, 7, 32'h55, 4'hF, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1, 7);
    chk("zero_reg", d2_rd1, 32'h0);
    chk("oor_read", d2_rd2, 32'h0);
    chk("no_zero_reg", d1_rd1, 32'hFF);
    chk("in_range7", d1_rd2, 32'h55);
    drive(0, 0, 0, 0, 0, 1, 3, 1, 5);
    chk("zr_keep3", d2_rd1, 32'h11BB33DD);
    chk("zr_keep5", d2_rd2, 32'h7E);

    // dual-port same address, then hold
    drive(0, 1, 2, 32'h3C, 4'hF, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 2, 1, 2);
    chk("dual_p1", {24'h0, d0_rd1}, 32'h3C);
    chk("dual_p2", {24'h0, d0_rd2}, 32'h3C);
    drive(0, 0, 0, 0, 0, 0, 2, 0, 2);
    chk("hold_valid1", {31'b0, d0_v1}, 32'h0);
    chk("hold_data1", {24'h0, d0_rd1}, 32'h3C);
    drive(0, 0, 0, 0, 0, 0, 2, 0, 2);
    chk("hold_valid2", {31'b0, d0_v2}, 32'h0);
    chk("hold_data2", {24'h0, d0_rd2}, 32'h3C);

    // reset on the same edge as a write and a read
    drive(1, 1, 1, 32'h99, 4'hF, 1, 1, 0, 0);
    chk("midrst_valid", {31'b0, d0_v1}, 32'h0);
    chk("midrst_data", d1_rd1, 32'h0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("midrst_read", d1_rd1, 32'h0);
    chk("midrst_rvalid", {31'b0, d1_v1}, 32'h1);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)));
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
